rdata_encrypt: RTL and testbench
================================

# rdata_encrypt

Downstream stage of the APB master in the ICB-to-APB crypto bridge. It accepts one 32-bit APB read-data word per `wdata_vld` pulse and buffers up to two words. Each word is encrypted with an iterative keyed ARX cipher, one round per cycle. The ciphertext is pushed into the read-return FIFO toward the ICB side. Its `full` output is the back-pressure seen by the APB master.

## Interface
- `ROUNDS`, 4: cipher rounds per word, legal range 1..16.
- `KEY`, 32'h0: 32-bit cipher key.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wdata` in 32: plaintext read data from the APB master.
- `wdata_vld` in 1: one-cycle strobe; `wdata` is valid in that cycle.
- `full` out 1: input buffer holds 2 words; upstream must not strobe.
- `fifo_full` in 1: read-return FIFO cannot accept a write this cycle.
- `fifo_wdata` out 32: ciphertext to the read-return FIFO.
- `fifo_wen` out 1: FIFO write enable.
- `busy` out 1: word buffered or in flight.
- `ovf` out 1: sticky flag; a strobe arrived while `full` was high.

## Operation
Input buffer:
- 2-entry FIFO with registered count `ibuf_cnt` (0..2).
- `full = (ibuf_cnt == 2)`.
- A strobe with `ibuf_cnt < 2` writes at the tail.
- A strobe with `ibuf_cnt == 2` is dropped and sets `ovf`. This holds even if a pop occurs in the same cycle.
- Push and pop in the same cycle leave the count unchanged; the data order is preserved.

State machine IDLE, ROUND, PUSH:
- IDLE: when `ibuf_cnt != 0`, load `x <= head`, pop the head, set `rnd <= 0`, go to ROUND.
- ROUND: `x <= F(x, rnd)` and `rnd <= rnd + 1`.
  - If `rnd == ROUNDS-1`, go to PUSH; otherwise stay in ROUND.
- PUSH: `fifo_wdata = x`, `fifo_wen = !fifo_full` (combinational).
  - If `!fifo_full`, go to IDLE; otherwise hold in PUSH with `x` unchanged.

Round function:
- `k_r = rotl(KEY, (8*r) mod 32)`.
- `F(x, r) = rotl(x ^ k_r, 3) + k_r`.
- The addition is modulo 2^32; the carry out is discarded.

Other outputs:
- `busy = (state != IDLE) || (ibuf_cnt != 0)`.
- `ovf` is cleared only by reset.
- `fifo_wen` is 0 outside PUSH.

Reset:
- Reset values: all outputs 0; state IDLE; `ibuf_cnt` 0; `x` 0; `rnd` 0; `ovf` 0.
- Reset mid-operation discards the buffered word and the in-flight word.
- No partial FIFO write is issued after reset deassertion.

## Timing
- Strobe sampled at the end of cycle t.
- `ibuf_cnt` becomes nonzero in cycle t+1; the state is still IDLE.
- ROUND occupies cycles t+2 .. t+1+ROUNDS.
- PUSH is in cycle t+2+ROUNDS; `fifo_wen` is high that cycle if `fifo_full` is low.
- Latency from strobe to `fifo_wen` is ROUNDS+2 cycles when the FIFO is not full.
- Throughput is one word per ROUNDS+2 cycles.
- The second buffered word enters ROUND in the cycle after the first word's successful PUSH plus one IDLE cycle.
- Each `fifo_full` cycle during PUSH adds one cycle of stall.
- `full` follows `ibuf_cnt` one cycle after the strobe; it is never combinational from `wdata_vld`.

## Test plan
- KEY=0, ROUNDS=4, strobe `wdata`=32'h0000_0001 at cycle 0:
  - `fifo_wen` high exactly at cycle 6 with `fifo_wdata`=32'h0000_1000.
  - `busy` is low at cycle 7.
- KEY=32'hFFFF_FFFF, ROUNDS=1, `wdata`=32'h0:
  - `fifo_wdata`=32'hFFFF_FFFE at cycle 3 (addition wraps).
- KEY=0, ROUNDS=4, 32'h0000_0001 strobed at cycle 0 and 32'h8000_0000 at cycle 1:
  - Writes 32'h0000_1000 at cycle 6, then 32'h0000_0800 at cycle 12, in order.
  - `full` is never asserted.
- Hold `fifo_full`=1 for 5 cycles starting at the PUSH cycle:
  - `fifo_wen` stays low and `fifo_wdata` is stable.
  - A single write occurs on the first cycle with `fifo_full` low.
- With `fifo_full`=1 held, strobe words A, B, C in cycles 0, 1 and 3:
  - After C, `full`=1.
  - A fourth strobe while `full`=1 sets `ovf`=1.
  - After release, the output order is A, B, C; the dropped word never appears.
- Assert `rst_n`=0 during ROUND with one word still buffered:
  - All outputs 0 immediately.
  - After release, `busy`=0 and no `fifo_wen` is seen over 20 cycles.

Source files
------------

// File: rtl/rdata_encrypt.sv
// Buffers up to two APB read words and ARX-encrypts each (one round per cycle) into the read-return FIFO.
// Strobe-to-fifo_wen latency is ROUNDS+2 cycles; registered full at two buffered words, and fifo_full stalls in PUSH.
module rdata_encrypt #(
  parameter int          ROUNDS = 4,
  parameter logic [31:0] KEY    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wdata,
  input  logic        wdata_vld,
  output logic        full,
  input  logic        fifo_full,
  output logic [31:0] fifo_wdata,
  output logic        fifo_wen,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, ROUND, PUSH} state_t;

  state_t      state, state_nxt;
  logic [31:0] ibuf [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  ibuf_cnt;
  logic [31:0] x, x_nxt;
  logic [3:0]  rnd, rnd_nxt;
  logic        push, pop;

  // Round key is KEY rotated left by 8*r bits, so only r mod 4 matters.
  function automatic logic [31:0] round_f(input logic [31:0] v, input logic [1:0] r);
    logic [31:0] k;
    logic [31:0] t;
    case (r)
      2'd0:    k = KEY;
      2'd1:    k = {KEY[23:0], KEY[31:24]};
      2'd2:    k = {KEY[15:0], KEY[31:16]};
      default: k = {KEY[7:0],  KEY[31:8]};
    endcase
    t = v ^ k;
    return {t[28:0], t[31:29]} + k;
  endfunction

  assign full = (ibuf_cnt == 2'd2);
  assign push = wdata_vld && !full;
  assign pop  = (state == IDLE) && (ibuf_cnt != 2'd0);
  assign busy = (state != IDLE) || (ibuf_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      ibuf_cnt <= 2'd0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   ibuf_cnt <= ibuf_cnt + 2'd1;
        2'b01:   ibuf_cnt <= ibuf_cnt - 2'd1;
        default: ibuf_cnt <= ibuf_cnt;
      endcase
      // A strobe against a full buffer is lost even if a pop frees a slot this cycle.
      if (wdata_vld && full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ibuf[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= 32'h0;
      rnd   <= 4'd0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      rnd   <= rnd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    x_nxt      = x;
    rnd_nxt    = rnd;
    fifo_wen   = 1'b0;
    fifo_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (pop) begin
          x_nxt     = ibuf[rd_ptr];
          rnd_nxt   = 4'd0;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        x_nxt   = round_f(x, rnd[1:0]);
        rnd_nxt = rnd + 4'd1;
        if (rnd == 4'(ROUNDS - 1)) state_nxt = PUSH;
      end
      PUSH: begin
        fifo_wdata = x;
        fifo_wen   = !fifo_full;
        if (!fifo_full) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rdata_encrypt.sv
// Directed bench for rdata_encrypt: a queue-based timing/cipher model checked every cycle, plus literal expectations.
module tb_rdata_encrypt;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] wdata = 32'h0;
  logic        wdata_vld = 1'b0;
  logic        fifo_full = 1'b0;
  logic        full, fifo_wen, busy, ovf;
  logic [31:0] fifo_wdata;

  logic [31:0] wdata2 = 32'h0;
  logic        vld2 = 1'b0;
  logic        ffull2 = 1'b0;
  logic        full2, wen2, busy2, ovf2;
  logic        full3, wen3, busy3, ovf3;
  logic [31:0] fdat2, fdat3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rdata_encrypt #(.ROUNDS(R), .KEY(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .wdata_vld(wdata_vld), .full(full),
    .fifo_full(fifo_full), .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen), .busy(busy), .ovf(ovf));

  rdata_encrypt #(.ROUNDS(1), .KEY(32'hFFFF_FFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .wdata(wdata2), .wdata_vld(vld2), .full(full2),
    .fifo_full(ffull2), .fifo_wdata(fdat2), .fifo_wen(wen2), .busy(busy2), .ovf(ovf2));

  rdata_encrypt #(.ROUNDS(2), .KEY(32'h0000_0001)) dut3 (
    .clk(clk), .rst_n(rst_n), .wdata(wdata2), .wdata_vld(vld2), .full(full3),
    .fifo_full(ffull2), .fifo_wdata(fdat3), .fifo_wen(wen3), .busy(busy3), .ovf(ovf3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] encrypt(input logic [31:0] p, input logic [31:0] key, input int rounds);
    logic [31:0] xv;
    logic [31:0] k;
    xv = p;
    for (int r = 0; r < rounds; r++) begin
      k  = rotl(key, (8 * r) % 32);
      xv = rotl(xv ^ k, 3) + k;
    end
    return xv;
  endfunction

  // Model: input buffer as a queue, cipher engine as a countdown to its push cycle.
  logic [31:0] m_buf[$];
  logic        eng_act = 1'b0;
  int          eng_wait = 0;
  logic [31:0] eng_word = 32'h0;
  logic        m_ovf = 1'b0;
  logic        was_full, take;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_buf.delete();
      eng_act  = 1'b0;
      eng_wait = 0;
      m_ovf    = 1'b0;
    end else begin
      was_full = (m_buf.size() == 2);
      take     = !eng_act && (m_buf.size() != 0);
      if (eng_act) begin
        if (eng_wait > 0) eng_wait--;
        else if (!fifo_full) eng_act = 1'b0;
      end
      if (take) begin
        eng_word = encrypt(m_buf.pop_front(), 32'h0, R);
        eng_act  = 1'b1;
        eng_wait = R;
      end
      if (wdata_vld) begin
        if (was_full) m_ovf = 1'b1;
        else m_buf.push_back(wdata);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk1("rst_full", full, 1'b0);
      chk1("rst_wen", fifo_wen, 1'b0);
      chk("rst_wdata", fifo_wdata, 32'h0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_ovf", ovf, 1'b0);
    end else begin
      chk1("full", full, m_buf.size() == 2);
      chk1("fifo_wen", fifo_wen, eng_act && eng_wait == 0 && !fifo_full);
      chk1("busy", busy, eng_act || m_buf.size() != 0);
      chk1("ovf", ovf, m_ovf);
      if (eng_act && eng_wait == 0) chk("fifo_wdata", fifo_wdata, eng_word);
    end
  end

  int          lg_cyc[$];
  logic [31:0] lg_dat[$];
  logic        full_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_wen) begin
        lg_cyc.push_back(cyc);
        lg_dat.push_back(fifo_wdata);
      end
      if (full) full_seen = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] d);
    wdata     = d;
    wdata_vld = 1'b1;
    @(posedge clk);
    #1;
    wdata_vld = 1'b0;
  endtask

  task automatic clear_log();
    lg_cyc.delete();
    lg_dat.delete();
    full_seen = 1'b0;
  endtask

  int t0;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("mdl_k0", encrypt(32'h1, 32'h0, 4), 32'h0000_1000);
    chk("mdl_kf", encrypt(32'h0, 32'hFFFF_FFFF, 1), 32'hFFFF_FFFE);
    chk("mdl_k1", encrypt(32'h0, 32'h1, 2), 32'h0000_0948);
    idle(2);

    // Single word, latency and busy drop.
    clear_log();
    t0 = cyc;
    strobe(32'h0000_0001);
    idle(6);
    @(negedge clk);
    chk1("t1_busy_low", busy, 1'b0);
    chk("t1_nwr", 32'(lg_dat.size()), 32'd1);
    if (lg_dat.size() >= 1) begin
      chk("t1_cycle", 32'(lg_cyc[0] - t0), 32'd6);
      chk("t1_data", lg_dat[0], 32'h0000_1000);
    end
    @(posedge clk);
    #1;
    idle(2);

    // Wrapping add (ROUNDS=1) and rotated round keys (ROUNDS=2, KEY=1).
    wdata2 = 32'h0;
    vld2   = 1'b1;
    @(posedge clk);
    #1;
    vld2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk1("t2_wen_r1", wen2, k == 3);
      chk1("t2_wen_r2", wen3, k == 4);
      if (k == 3) chk("t2_data_r1", fdat2, 32'hFFFF_FFFE);
      if (k == 4) chk("t2_data_r2", fdat3, 32'h0000_0948);
      @(posedge clk);
      #1;
    end

    // Back-to-back words keep order and never fill the buffer.
    clear_log();
    t0 = cyc;
    strobe(32'h0000_0001);
    strobe(32'h8000_0000);
    idle(12);
    chk("t3_nwr", 32'(lg_dat.size()), 32'd2);
    if (lg_dat.size() >= 2) begin
      chk("t3_cyc0", 32'(lg_cyc[0] - t0), 32'd6);
      chk("t3_dat0", lg_dat[0], 32'h0000_1000);
      chk("t3_cyc1", 32'(lg_cyc[1] - t0), 32'd12);
      chk("t3_dat1", lg_dat[1], 32'h0000_0800);
    end
    chk1("t3_full_seen", full_seen, 1'b0);

    // FIFO stall of five cycles at the PUSH cycle.
    clear_log();
    t0 = cyc;
    strobe(32'hDEAD_BEEF);
    idle(5);
    fifo_full = 1'b1;
    idle(5);
    fifo_full = 1'b0;
    idle(3);
    chk("t4_nwr", 32'(lg_dat.size()), 32'd1);
    if (lg_dat.size() >= 1) begin
      chk("t4_cycle", 32'(lg_cyc[0] - t0), 32'd11);
      chk("t4_data", lg_dat[0], 32'hDBEE_FDEA);
    end

    // Fill the buffer behind a blocked FIFO, then overflow it.
    clear_log();
    fifo_full = 1'b1;
    strobe(32'h0000_0002);
    strobe(32'h0000_0003);
    idle(1);
    strobe(32'h0001_0000);
    wdata     = 32'h0000_00FF;
    wdata_vld = 1'b1;
    @(negedge clk);
    chk1("t5_full", full, 1'b1);
    @(posedge clk);
    #1;
    wdata_vld = 1'b0;
    @(negedge clk);
    chk1("t5_ovf", ovf, 1'b1);
    @(posedge clk);
    #1;
    idle(2);
    fifo_full = 1'b0;
    idle(16);
    chk("t5_nwr", 32'(lg_dat.size()), 32'd3);
    if (lg_dat.size() >= 3) begin
      chk("t5_a", lg_dat[0], 32'h0000_2000);
      chk("t5_b", lg_dat[1], 32'h0000_3000);
      chk("t5_c", lg_dat[2], 32'h1000_0000);
    end

    // Reset during ROUND with a second word buffered.
    clear_log();
    strobe(32'h0000_0005);
    strobe(32'h0000_0006);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk1("t6_full", full, 1'b0);
    chk1("t6_wen", fifo_wen, 1'b0);
    chk("t6_wdata", fifo_wdata, 32'h0);
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_ovf", ovf, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);
    chk("t6_nwr", 32'(lg_dat.size()), 32'd0);
    @(negedge clk);
    chk1("t6_busy_after", busy, 1'b0);
    chk("aux_idle", {26'h0, busy2, busy3, ovf2, ovf3, full2, full3}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
